// File: rtl/sb_tx_pkg.sv
// Shared constants, frame geometry and FSM state type for the sideband TX serializer.
package sb_tx_pkg;

  localparam int unsigned HDR_W  = 4;
  localparam int unsigned SEQ_W  = 3;
  localparam logic [HDR_W-1:0] SB_HDR = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } sb_tx_state_e;

  // Header, code, sequence number and one parity bit.
  function automatic int unsigned frame_w(input int unsigned msg_w);
    return msg_w + HDR_W + SEQ_W + 1;
  endfunction

endpackage

// File: rtl/sb_tx_fifo.sv
// Synchronous FIFO buffering captured sideband codes; depth must be a power of two.
module sb_tx_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // Push and pop each qualify against the pre-edge occupancy.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sb_tx_msg_serializer.sv
// Sideband TX stage: captures wrapper message codes, frames them and shifts them out LSB first.
// Build option SB_TX_PARITY_EN enables the even-parity frame MSB (otherwise driven 0).
module sb_tx_msg_serializer
  import sb_tx_pkg::*;
#(
  parameter int unsigned SB_MSG_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GAP_CYCLES   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_TX_SbMessage,
  output logic                    o_sb_data,
  output logic                    o_sb_valid,
  output logic                    o_busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_fifo_full,
  output logic                    o_overflow
);

  localparam int unsigned FRAME_W = frame_w(SB_MSG_WIDTH);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sb_tx_state_e            state;
  logic [FRAME_W-1:0]      shreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [SEQ_W-1:0]        seq;

  logic                    prev_valid;
  logic [SB_MSG_WIDTH-1:0] prev_code;
  logic                    capture_c;
  logic                    push_c;
  logic                    pop_c;

  logic [SB_MSG_WIDTH-1:0] head_code;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    parity_c;
  logic [FRAME_W-1:0]      frame_c;

  // A new code is a rising valid or a code change while valid stays high.
  assign capture_c   = i_tx_msg_valid && (!prev_valid || (i_TX_SbMessage != prev_code));
  assign push_c      = capture_c && !fifo_full;
  assign pop_c       = (state == LOAD);
  assign o_fifo_full = fifo_full;

  sb_tx_fifo #(
    .DATA_W (SB_MSG_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push_c),
    .wr_data (i_TX_SbMessage),
    .pop     (pop_c),
    .rd_data (head_code),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
`ifdef SB_TX_PARITY_EN
    parity_c = ^{head_code, seq};
`else
    parity_c = 1'b0;
`endif
    frame_c = {parity_c, seq, head_code, SB_HDR};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_valid <= 1'b0;
      prev_code  <= '0;
      o_overflow <= 1'b0;
    end else begin
      prev_valid <= i_tx_msg_valid;
      prev_code  <= i_TX_SbMessage;
      if (capture_c && fifo_full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Lane FSM; busy and the serial outputs are registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      shreg               <= '0;
      bit_cnt             <= '0;
      gap_cnt             <= '0;
      seq                 <= '0;
      o_sb_data           <= 1'b0;
      o_sb_valid          <= 1'b0;
      o_busy              <= 1'b0;
      o_falling_edge_busy <= 1'b0;
    end else begin
      o_falling_edge_busy <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state  <= LOAD;
            o_busy <= 1'b1;
          end
        end
        LOAD: begin
          state      <= SEND;
          shreg      <= frame_c >> 1;
          o_sb_data  <= frame_c[0];
          o_sb_valid <= 1'b1;
          bit_cnt    <= '0;
          seq        <= seq + SEQ_W'(1);
        end
        SEND: begin
          if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
            state      <= GAP;
            o_sb_data  <= 1'b0;
            o_sb_valid <= 1'b0;
            gap_cnt    <= '0;
          end else begin
            o_sb_data <= shreg[0];
            shreg     <= shreg >> 1;
            bit_cnt   <= bit_cnt + BIT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            if (!fifo_empty) begin
              state <= LOAD;
            end else begin
              state               <= IDLE;
              o_busy              <= 1'b0;
              o_falling_edge_busy <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_tx_msg_serializer.sv
// Directed bench for sb_tx_msg_serializer: frame content/timing, capture rules, overflow, seq wrap, reset.
module tb_sb_tx_msg_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] code = 4'h0;
  logic       o_sb_data, o_sb_valid, o_busy, o_falling_edge_busy, o_fifo_full, o_overflow;

  int n_cmp = 0;
  int n_err = 0;

  sb_tx_msg_serializer #(
    .SB_MSG_WIDTH (4),
    .FIFO_DEPTH   (4),
    .GAP_CYCLES   (32)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_tx_msg_valid      (valid),
    .i_TX_SbMessage      (code),
    .o_sb_data           (o_sb_data),
    .o_sb_valid          (o_sb_valid),
    .o_busy              (o_busy),
    .o_falling_edge_busy (o_falling_edge_busy),
    .o_fifo_full         (o_fifo_full),
    .o_overflow          (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [11:0] bits;
  } frame_t;

  typedef struct {
    logic [3:0]  code;
    logic [11:0] frame;
  } vec_t;

  // Frame collector: assembles every o_sb_valid burst and counts busy events.
  frame_t      fq[$];
  logic [11:0] mon_bits = '0;
  int          mon_len = 0;
  logic        mon_prev_v = 1'b0;
  logic        mon_prev_busy = 1'b0;
  int          n_frames = 0;
  int          n_pulses = 0;
  int          n_drops = 0;
  bit          full_seen = 1'b0;

  always @(negedge clk) begin
    if (o_sb_valid) begin
      if (mon_len < 12) mon_bits[mon_len] = o_sb_data;
      mon_len++;
    end else if (mon_prev_v) begin
      fq.push_back('{mon_len, mon_bits});
      n_frames++;
      mon_len  = 0;
      mon_bits = '0;
    end
    if (o_falling_edge_busy) n_pulses++;
    if (mon_prev_busy && !o_busy) n_drops++;
    if (o_fifo_full) full_seen = 1'b1;
    mon_prev_v    = o_sb_valid;
    mon_prev_busy = o_busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] fixp(input logic [11:0] f);
`ifdef SB_TX_PARITY_EN
    return f;
`else
    return {1'b0, f[10:0]};
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    valid = 1'b0;
    code  = 4'h0;
    repeat (3) @(negedge clk);
    check({nm, "_rst_outs"},
          {26'd0, o_sb_data, o_sb_valid, o_busy, o_falling_edge_busy, o_fifo_full, o_overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    fq.delete();
  endtask

  task automatic pulse(input logic [3:0] c);
    @(negedge clk);
    valid = 1'b1;
    code  = c;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [11:0] exp, input string nm);
    frame_t f;
    int n = 0;
    while (fq.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (fq.size() == 0) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      f = fq.pop_front();
      check({nm, "_len"}, 32'(f.len), 32'd12);
      check({nm, "_bits"}, {20'd0, f.bits}, {20'd0, fixp(exp)});
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (o_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle"}, {31'd0, o_busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  vec_t burst[5];
  vec_t wrap[9];

  initial begin
    logic [11:0] exp1;
    int base_f, base_p, base_d;

    // Codes 1..5 sent with seq 0..4; sixth code of the burst is dropped.
    burst[0] = '{4'h1, 12'h81B};
    burst[1] = '{4'h2, 12'h12B};
    burst[2] = '{4'h3, 12'hA3B};
    burst[3] = '{4'h4, 12'hB4B};
    burst[4] = '{4'h5, 12'hC5B};
    // Code 6 repeated, seq 0..7 then wrapping back to 0.
    wrap[0] = '{4'h6, 12'h06B};
    wrap[1] = '{4'h6, 12'h96B};
    wrap[2] = '{4'h6, 12'hA6B};
    wrap[3] = '{4'h6, 12'h36B};
    wrap[4] = '{4'h6, 12'hC6B};
    wrap[5] = '{4'h6, 12'h56B};
    wrap[6] = '{4'h6, 12'h66B};
    wrap[7] = '{4'h6, 12'hF6B};
    wrap[8] = '{4'h6, 12'h06B};

    // Single code 5: exact bit timing, busy window and falling-edge pulse.
    do_reset("t1");
    exp1 = fixp(12'h05B);
    @(negedge clk);
    valid = 1'b1;
    code  = 4'h5;
    @(negedge clk);
    valid = 1'b0;
    check("t1_busy_N", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    check("t1_load", {30'd0, o_busy, o_sb_valid}, 32'd2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("t1_bit%0d", i), {30'd0, o_sb_valid, o_sb_data}, {30'd0, 1'b1, exp1[i]});
    end
    @(negedge clk);
    check("t1_gap_start", {30'd0, o_busy, o_sb_valid}, 32'd2);
    repeat (31) @(negedge clk);
    check("t1_gap_end", {30'd0, o_busy, o_falling_edge_busy}, 32'd2);
    @(negedge clk);
    check("t1_busy_fall", {30'd0, o_busy, o_falling_edge_busy}, 32'd1);
    @(negedge clk);
    check("t1_pulse_end", {31'd0, o_falling_edge_busy}, 32'd0);

    // Valid held ~20 cycles with a stable code: one frame only.
    do_reset("t2");
    base_f = n_frames;
    @(negedge clk);
    valid = 1'b1;
    code  = 4'h3;
    expect_frame(12'h03B, "t2_frame");
    repeat (6) @(negedge clk);
    valid = 1'b0;
    wait_idle("t2");
    check("t2_nframes", 32'(n_frames - base_f), 32'd1);

    // Code steps on consecutive cycles: back-to-back frames, one busy drop.
    do_reset("t3");
    base_f = n_frames;
    base_p = n_pulses;
    base_d = n_drops;
    @(negedge clk);
    valid = 1'b1;
    code  = 4'h1;
    @(negedge clk);
    code = 4'h2;
    @(negedge clk);
    code = 4'h3;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 3; i++) expect_frame(burst[i].frame, $sformatf("t3_frame%0d", i));
    wait_idle("t3");
    check("t3_nframes", 32'(n_frames - base_f), 32'd3);
    check("t3_pulses", 32'(n_pulses - base_p), 32'd1);
    check("t3_drops", 32'(n_drops - base_d), 32'd1);

    // Six codes in six cycles: five stored, sixth dropped, overflow sticky.
    do_reset("t4");
    base_f    = n_frames;
    full_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid = 1'b1;
      code  = 4'(i + 1);
    end
    @(negedge clk);
    valid = 1'b0;
    check("t4_full", {31'd0, o_fifo_full}, 32'd1);
    check("t4_overflow", {31'd0, o_overflow}, 32'd1);
    for (int i = 0; i < 5; i++) expect_frame(burst[i].frame, $sformatf("t4_frame%0d", i));
    wait_idle("t4");
    check("t4_nframes", 32'(n_frames - base_f), 32'd5);
    check("t4_full_seen", {31'd0, full_seen}, 32'd1);
    check("t4_overflow_sticky", {30'd0, o_overflow, o_fifo_full}, 32'd2);

    // Nine single frames: seq wraps 7 -> 0.
    do_reset("t5");
    for (int i = 0; i < 9; i++) begin
      pulse(wrap[i].code);
      expect_frame(wrap[i].frame, $sformatf("t5_frame%0d", i));
    end
    wait_idle("t5");

    // Reset mid-SEND with a queued code: no stale frame afterwards, seq restarts.
    do_reset("t6");
    pulse(4'h5);
    begin
      int n = 0;
      while (!o_sb_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_sending", {31'd0, o_sb_valid}, 32'd1);
    @(negedge clk);
    valid = 1'b1;
    code  = 4'h7;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_rst",
          {26'd0, o_sb_data, o_sb_valid, o_busy, o_falling_edge_busy, o_fifo_full, o_overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fq.delete();
    check("t6_idle_after", {31'd0, o_busy}, 32'd0);
    pulse(4'h9);
    expect_frame(12'h09B, "t6_frame");
    wait_idle("t6");
    repeat (10) @(negedge clk);
    check("t6_no_stale", 32'(fq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
